cmd_out_shaper: RTL and testbench

- Output-side counterpart of the per-channel input debounce filter.
- Takes NUM_SIGNALS requested command states from control logic and drives the command output lines (relay/optocoupler drivers).
- Enforces a minimum ON time and a minimum OFF time per channel, so short or chattering requests never reach the hardware.
- A global enable forces all outputs off immediately.

---
 rtl/cmd_out_pkg.sv | 23 ++
 rtl/cmd_out_ch.sv | 95 +++++++++
 rtl/cmd_out_shaper.sv | 65 ++++++
 tb/tb_cmd_out_shaper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_out_pkg.sv
// Shared types and elaboration helpers for the command output shaper.
// Holds the per-channel state encoding and the counter width helpers.
package cmd_out_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON_HOLD  = 2'd1,
        ST_ON       = 2'd2,
        ST_OFF_HOLD = 2'd3
    } ch_state_e;

    // Counter widths never collapse to zero bits, even for a limit of 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_out_ch.sv
// One command channel: enforces minimum ON/OFF dwell, counted in prescaler ticks.
// en low drops the channel to OFF at the next edge, ignoring any pending dwell.
module cmd_out_ch
    import cmd_out_pkg::*;
#(
    parameter int MIN_ON  = 10,
    parameter int MIN_OFF = 10,
    parameter int CNT_W   = 4
) (
    input  logic i_clk,
    input  logic i_aclr_n,
    input  logic i_tick,
    input  logic i_en,
    input  logic i_in,
    output logic o_out,
    output logic o_hold
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

    ch_state_e        r_state;
    ch_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_out;
    logic             r_hold;

    always_ff @(posedge i_clk or negedge i_aclr_n) begin
        if (!i_aclr_n) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_out   <= (w_state_next == ST_ON_HOLD) || (w_state_next == ST_ON);
            r_hold  <= (w_state_next == ST_ON_HOLD) || (w_state_next == ST_OFF_HOLD);
        end
    end

    // Hold states exit on the MIN-th tick, so cnt never needs to reach MIN.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!i_en) begin
            w_state_next = ST_OFF;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (i_in) begin
                        w_state_next = ST_ON_HOLD;
                        w_cnt_next   = '0;
                    end
                end
                ST_ON_HOLD: begin
                    if (i_tick) begin
                        if (r_cnt == ON_LAST) begin
                            w_state_next = i_in ? ST_ON : ST_OFF_HOLD;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ON: begin
                    if (!i_in) begin
                        w_state_next = ST_OFF_HOLD;
                        w_cnt_next   = '0;
                    end
                end
                ST_OFF_HOLD: begin
                    if (i_tick) begin
                        if (r_cnt == OFF_LAST) begin
                            w_state_next = i_in ? ST_ON_HOLD : ST_OFF;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_OFF;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign o_out  = r_out;
    assign o_hold = r_hold;

endmodule

// File: rtl/cmd_out_shaper.sv
// Command output shaper: shared hold-time prescaler plus NUM_SIGNALS independent
// channels that impose minimum ON/OFF times on relay/optocoupler drive lines.
module cmd_out_shaper
    import cmd_out_pkg::*;
#(
    parameter int NUM_SIGNALS = 16,
    parameter int TICK_DIV    = 1000,
    parameter int MIN_ON      = 10,
    parameter int MIN_OFF     = 10
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   en,
    input  logic [NUM_SIGNALS-1:0] in,
    output logic [NUM_SIGNALS-1:0] out,
    output logic [NUM_SIGNALS-1:0] hold,
    output logic                   tick
);

    localparam int                PRESC_W   = clog2_min1(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam int                CNT_W     = clog2_min1(max_int(MIN_ON, MIN_OFF));

    if ((MIN_ON < 1) || (MIN_OFF < 1) || (TICK_DIV < 1)) begin : g_param_err
        $error("cmd_out_shaper: MIN_ON, MIN_OFF and TICK_DIV must all be >= 1");
    end

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_next;
    logic               r_tick;

    always_comb begin
        w_presc_next = (r_presc == PRESC_MAX) ? '0 : r_presc + PRESC_W'(1);
    end

    // tick is registered alongside the counter so it is high exactly while r_presc==TICK_DIV-1.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_next;
            r_tick  <= (w_presc_next == PRESC_MAX);
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < NUM_SIGNALS; g++) begin : g_ch
        cmd_out_ch #(
            .MIN_ON (MIN_ON),
            .MIN_OFF(MIN_OFF),
            .CNT_W  (CNT_W)
        ) u_ch (
            .i_clk   (clk),
            .i_aclr_n(aclr_n),
            .i_tick  (r_tick),
            .i_en    (en),
            .i_in    (in[g]),
            .o_out   (out[g]),
            .o_hold  (hold[g])
        );
    end

endmodule

// File: tb/tb_cmd_out_shaper.sv
// Bench for cmd_out_shaper: two instances (TICK_DIV=1 and TICK_DIV=4) checked every
// cycle against a dwell-countdown model, plus directed literal expectations.
module tb_cmd_out_shaper;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          a_en, b_en;
    logic [NS-1:0] a_in, b_in;
    logic [NS-1:0] a_out, a_hold, b_out, b_hold;
    logic          a_tick, b_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    cmd_out_shaper #(.NUM_SIGNALS(NS), .TICK_DIV(1), .MIN_ON(3), .MIN_OFF(2)) dut_a (
        .clk(clk), .aclr_n(aclr_n), .en(a_en), .in(a_in),
        .out(a_out), .hold(a_hold), .tick(a_tick)
    );

    cmd_out_shaper #(.NUM_SIGNALS(NS), .TICK_DIV(4), .MIN_ON(2), .MIN_OFF(2)) dut_b (
        .clk(clk), .aclr_n(aclr_n), .en(b_en), .in(b_in),
        .out(b_out), .hold(b_hold), .tick(b_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Output level follows the request; each level change starts a dwell of
    // MIN ticks during which the request is ignored. en low clears everything.
    typedef struct packed {
        logic       lvl;
        logic [7:0] left;
    } mch_t;

    mch_t m_st [2][NS];
    int   m_edges;

    function automatic int p_td(input int d);  return (d == 0) ? 1 : 4; endfunction
    function automatic int p_on(input int d);  return (d == 0) ? 3 : 2; endfunction
    function automatic int p_off(input int d); return 2; endfunction

    function automatic logic tick_at(input int d, input int edges);
        return (edges > 0) && ((edges % p_td(d)) == (p_td(d) - 1));
    endfunction

    function automatic mch_t step_ch(input int d, input logic en, input logic rq,
                                     input logic tk, input mch_t cur);
        mch_t       nx;
        logic [7:0] left;
        nx = cur;
        if (!en) begin
            nx.lvl  = 1'b0;
            nx.left = 8'd0;
            return nx;
        end
        left = cur.left;
        if (left != 8'd0) begin
            if (!tk) return nx;
            left = left - 8'd1;
        end
        nx.left = left;
        if ((left == 8'd0) && (rq != cur.lvl)) begin
            nx.lvl  = rq;
            nx.left = rq ? 8'(p_on(d)) : 8'(p_off(d));
        end
        return nx;
    endfunction

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            m_edges <= 0;
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < NS; ch++)
                    m_st[d][ch] <= '0;
        end else begin
            for (int ch = 0; ch < NS; ch++) begin
                m_st[0][ch] <= step_ch(0, a_en, a_in[ch], tick_at(0, m_edges), m_st[0][ch]);
                m_st[1][ch] <= step_ch(1, b_en, b_in[ch], tick_at(1, m_edges), m_st[1][ch]);
            end
            m_edges <= m_edges + 1;
        end
    end

    function automatic logic [NS-1:0] exp_out(input int d);
        logic [NS-1:0] r;
        for (int ch = 0; ch < NS; ch++) r[ch] = m_st[d][ch].lvl;
        return r;
    endfunction

    function automatic logic [NS-1:0] exp_hold(input int d);
        logic [NS-1:0] r;
        for (int ch = 0; ch < NS; ch++) r[ch] = (m_st[d][ch].left != 8'd0);
        return r;
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        chk("a_out_model",  32'(a_out),  32'(exp_out(0)));
        chk("a_hold_model", 32'(a_hold), 32'(exp_hold(0)));
        chk("a_tick_model", 32'(a_tick), 32'(tick_at(0, m_edges)));
        chk("b_out_model",  32'(b_out),  32'(exp_out(1)));
        chk("b_hold_model", 32'(b_hold), 32'(exp_hold(1)));
        chk("b_tick_model", 32'(b_tick), 32'(tick_at(1, m_edges)));
    end

    // ---------------- driver tasks ----------------
    // pat[j] is the request during the cycle after edge k+j; eo/eh[j] the outputs after edge k+j.
    task automatic run_seq(input string name, input int ch, input logic [15:0] pat,
                           input int n, input logic [15:0] eo, input logic [15:0] eh);
        @(posedge clk); #1 a_in[ch] = pat[0];
        for (int j = 1; j <= n; j++) begin
            @(posedge clk); #1 a_in[ch] = pat[j];
            @(negedge clk);
            chk({name, "_out"},  32'(a_out[ch]),  32'(eo[j]));
            chk({name, "_hold"}, 32'(a_hold[ch]), 32'(eh[j]));
        end
        a_in[ch] = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    // Entry on an edge leaving the prescaler at phase s gives 8-s clk of ON_HOLD.
    task automatic measure_phase(input int s);
        int dur;
        bit done;
        repeat (12) @(posedge clk);
        #1;
        for (int k = 0; k < 4 && ((m_edges % 4) != ((s + 3) % 4)); k++) begin
            @(posedge clk); #1;
        end
        b_in[3] = 1'b1;
        @(posedge clk); #1 b_in[3] = 1'b0;
        dur  = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (b_out[3] === 1'b1) dur++;
            else done = 1;
        end
        chk("b_hi_time",  32'(dur), 32'(8 - s));
        chk("b_hi_range", 32'((dur >= 5) && (dur <= 8)), 32'd1);
    endtask

    task automatic check_tick_period();
        int gap;
        bit seen;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (b_tick === 1'b1) seen = 1;
        end
        gap  = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            gap++;
            if (b_tick === 1'b1) seen = 1;
        end
        chk("b_tick_period", 32'(gap), 32'd4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_en = 1'b1; b_en = 1'b1;
        a_in = '0;   b_in = '0;
        aclr_n = 1'b1;
        #1 aclr_n = 1'b0;
        #2;
        chk("rst_a_out",  32'(a_out),  32'd0);
        chk("rst_a_hold", 32'(a_hold), 32'd0);
        chk("rst_a_tick", 32'(a_tick), 32'd0);
        chk("rst_b_out",  32'(b_out),  32'd0);
        chk("rst_b_tick", 32'(b_tick), 32'd0);
        @(posedge clk);
        @(posedge clk); #1 aclr_n = 1'b1;
        repeat (3) @(posedge clk);

        // single-clk pulse: 3 clk ON_HOLD then 2 clk OFF_HOLD
        run_seq("pulse", 0, 16'h0001, 6, 16'h000E, 16'h003E);
        // 10 clk request: follows in, dwell only at start and after the fall
        run_seq("long", 1, 16'h03FF, 13, 16'h07FE, 16'h180E);
        // chattering request: never narrower than 3 high / 2 low
        run_seq("chatter", 2, 16'h0035, 11, 16'h01CE, 16'h07FE);

        for (int s = 0; s < 4; s++) measure_phase(s);
        check_tick_period();

        // en drop mid-ON_HOLD, then re-enable with requests still high
        repeat (10) @(posedge clk);
        #1 a_in = '1;
        @(posedge clk);
        @(posedge clk); #1 a_en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("en_off_out",  32'(a_out),  32'd0);
        chk("en_off_hold", 32'(a_hold), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("en_off_in1_out", 32'(a_out), 32'd0);
        a_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); @(negedge clk);
            chk("en_back_out",  32'(a_out),  32'hF);
            chk("en_back_hold", 32'(a_hold), (j < 3) ? 32'hF : 32'h0);
        end

        // asynchronous reset while channels are ON
        @(posedge clk); #2 aclr_n = 1'b0;
        #1;
        chk("arst_out",    32'(a_out),  32'd0);
        chk("arst_hold",   32'(a_hold), 32'd0);
        chk("arst_a_tick", 32'(a_tick), 32'd0);
        chk("arst_b_tick", 32'(b_tick), 32'd0);
        @(posedge clk);
        @(posedge clk); #1 aclr_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_out",  32'(a_out),  32'hF);
        chk("post_rst_hold", 32'(a_hold), 32'hF);
        chk("post_rst_tick", 32'(a_tick), 32'd1);

        a_in = '0;
        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
